keyboard_ctrl: RTL and testbench

// - Sequences the USB-keycode-to-ASCII translator (ascii_gen) and presents the result as the

---
 rtl/keyboard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_keyboard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_ctrl.sv
// ---------------------------------------------------------------------------
// keyboard_ctrl
//
// Purpose:
//   Apple II keyboard register built on a USB HID keycode stream. The raw
//   keycode/shift are registered and fed to an external keycode-to-ASCII
//   translator (ascii_gen). A new key must be stable for DEBOUNCE_CYC cycles
//   before one ASCII character is latched. Holding the key produces typematic
//   repeats. The 6502 sees the latched character at $C000-$C00F, with the
//   strobe in bit 7. Any access to $C010-$C01F clears the strobe.
//
// Ports:
//   Clk          in   system clock
//   Reset        in   asynchronous, active-high reset
//   keycode[7:0] in   HID keycode, 8'h00 = no key
//   shift        in   shift modifier
//   gen_keycode  out  registered keycode driven to ascii_gen
//   gen_shift    out  registered shift driven to ascii_gen
//   gen_ascii    in   ascii_gen result, 8'h00 = unmapped key
//   addr[15:0]   in   6502 address bus
//   rd_en        in   bus read strobe
//   wr_en        in   bus write strobe
//   data_out     out  {strobe, data[6:0]} on reads of $C00x, else 8'h00
//   kbd_strobe   out  keyboard strobe flag
// ---------------------------------------------------------------------------
module keyboard_ctrl #(
  parameter int DEBOUNCE_CYC     = 50000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000,
  parameter int REPEAT_EN        = 1,
  parameter int CNT_W            = 25
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        shift,
  output logic [7:0]  gen_keycode,
  output logic        gen_shift,
  input  logic [7:0]  gen_ascii,
  input  logic [15:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  output logic [7:0]  data_out,
  output logic        kbd_strobe
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    HELD,
    REPEAT,
    WAIT_REL
  } state_t;

  // Terminal counts: each interval of N cycles ends when the counter hits N-1.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RAT_LAST = CNT_W'(REPEAT_RATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       kc_q, kc_d;
  logic             sh_q, sh_d;
  logic [6:0]       kbd_data_q, kbd_data_d;
  logic             kbd_strobe_q, kbd_strobe_d;

  logic change;
  logic latch;
  logic clr_hit;
  logic rd_hit;

  // Only addr[15:4] selects the register; the low nibble is a don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[3:0];

  assign clr_hit = (rd_en | wr_en) && (addr[15:4] == 12'hC01);
  assign rd_hit  = rd_en && (addr[15:4] == 12'hC00);

  // The raw input is compared with last cycle's registered copy, so a change
  // is seen on the very edge that also captures the new keycode.
  assign change = (keycode != kc_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    kc_d    = keycode;
    sh_d    = shift;

    if (change) begin
      // A change in any state restarts the debounce (rollover included) or,
      // on release, returns to IDLE.
      cnt_d   = '0;
      state_d = (keycode != 8'h00) ? SETTLE : IDLE;
    end else begin
      unique case (state_q)
        IDLE: ;
        SETTLE: begin
          if (cnt_q == DEB_LAST) begin
            cnt_d = '0;
            if (gen_ascii != 8'h00) begin
              latch   = 1'b1;
              state_d = HELD;
            end else begin
              state_d = WAIT_REL;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (REPEAT_EN != 0) begin
            if (cnt_q == DLY_LAST) begin
              latch   = 1'b1;
              cnt_d   = '0;
              state_d = REPEAT;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        REPEAT: begin
          if (cnt_q == RAT_LAST) begin
            latch = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        WAIT_REL: ;
        default: state_d = IDLE;
      endcase
    end

    // A latch takes priority over a simultaneous strobe clear.
    kbd_data_d   = latch ? gen_ascii[6:0] : kbd_data_q;
    kbd_strobe_d = latch ? 1'b1 : (clr_hit ? 1'b0 : kbd_strobe_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      kc_q         <= 8'h00;
      sh_q         <= 1'b0;
      kbd_data_q   <= 7'h00;
      kbd_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kc_q         <= kc_d;
      sh_q         <= sh_d;
      kbd_data_q   <= kbd_data_d;
      kbd_strobe_q <= kbd_strobe_d;
    end
  end

  assign gen_keycode = kc_q;
  assign gen_shift   = sh_q;
  assign kbd_strobe  = kbd_strobe_q;
  assign data_out    = rd_hit ? {kbd_strobe_q, kbd_data_q} : 8'h00;

endmodule

// File: tb/tb_keyboard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keyboard_ctrl
//
// Scoreboard bench for keyboard_ctrl with short timing parameters
// (debounce 4, repeat delay 20, repeat rate 8). A behavioural ascii_gen is
// attached to the translator ports. Each key press pushes the latch events it
// must cause (edge number + ASCII) into a queue. The auto-run loop compares
// every cycle: a latch must appear exactly on the queued edge with the queued
// data, otherwise the strobe must stay low. The loop acknowledges each latch
// by writing $C010. Directed sections cover clear/latch collision, address
// decode and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_keyboard_ctrl;

  localparam int DEB = 4;
  localparam int RDL = 20;
  localparam int RRT = 8;

  logic        Clk;
  logic        Reset;
  logic [7:0]  keycode;
  logic        shift;
  logic [7:0]  gen_keycode;
  logic        gen_shift;
  logic [7:0]  gen_ascii;
  logic [15:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [7:0]  data_out;
  logic        kbd_strobe;

  keyboard_ctrl #(
    .DEBOUNCE_CYC    (DEB),
    .REPEAT_DELAY_CYC(RDL),
    .REPEAT_RATE_CYC (RRT),
    .REPEAT_EN       (1),
    .CNT_W           (25)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .shift      (shift),
    .gen_keycode(gen_keycode),
    .gen_shift  (gen_shift),
    .gen_ascii  (gen_ascii),
    .addr       (addr),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .kbd_strobe (kbd_strobe)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural translator (Apple II upper-case ASCII).
  function automatic logic [7:0] ascii_of(input logic [7:0] kc, input logic sh);
    case (kc)
      8'h04:   return 8'h41;
      8'h1E:   return sh ? 8'h21 : 8'h31;
      8'h22:   return sh ? 8'h25 : 8'h35;
      8'h28:   return 8'h0D;
      8'h2C:   return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  always_comb gen_ascii = ascii_of(gen_keycode, gen_shift);

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one edge; restore the default read of $C000 away from the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
    addr  = 16'hC000;
    rd_en = 1'b1;
    wr_en = 1'b0;
    #1;
  endtask

  task automatic bus_clear();
    addr  = 16'hC010;
    rd_en = 1'b0;
    wr_en = 1'b1;
  endtask

  // Latch schedule for a key applied now and held for 'hold' edges.
  task automatic push_latches(input logic [7:0] kc, input logic sh, input int hold);
    logic [7:0] a;
    int         e;
    int         start;
    start = cyc;
    a     = ascii_of(kc, sh);
    if (a != 8'h00) begin
      e = start + DEB + 1;
      if (e <= start + hold) exp_q.push_back('{e, a});
      e += RDL;
      while (e <= start + hold) begin
        exp_q.push_back('{e, a});
        e += RRT;
      end
    end
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("latch_strobe", {7'b0, kbd_strobe}, 8'h01);
        check("latch_data", data_out, {1'b1, e.data[6:0]});
        bus_clear();
      end else begin
        check("idle_strobe", {7'b0, kbd_strobe}, 8'h00);
      end
    end
  endtask

  task automatic press(input logic [7:0] kc, input logic sh, input int hold);
    push_latches(kc, sh, hold);
    keycode = kc;
    shift   = sh;
    run(hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (edge %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    Reset   = 1'b1;
    keycode = 8'h00;
    shift   = 1'b0;
    addr    = 16'hC000;
    rd_en   = 1'b1;
    wr_en   = 1'b0;
    #22;
    check("rst_strobe", {7'b0, kbd_strobe}, 8'h00);
    check("rst_data", data_out, 8'h00);
    check("rst_gen_kc", gen_keycode, 8'h00);
    check("rst_gen_sh", {7'b0, gen_shift}, 8'h00);
    Reset = 1'b0;
    run(3);

    // Single press, released before the repeat delay.
    press(8'h04, 1'b0, 10);
    press(8'h00, 1'b0, 25);

    // Held key with shift: first latch, delayed repeat, then rate repeats.
    press(8'h1E, 1'b1, 60);
    press(8'h00, 1'b0, 10);

    // Glitch to zero during debounce restarts the debounce.
    press(8'h22, 1'b0, 3);
    press(8'h00, 1'b0, 2);
    press(8'h22, 1'b0, 20);
    press(8'h00, 1'b0, 10);
    check("q_empty_a", 8'(exp_q.size()), 8'h00);

    // Clear behaviour and clear/latch collision.
    k = cyc;
    keycode = 8'h28;
    shift   = 1'b0;
    while (cyc < k + DEB + 1) tick();
    check("enter_strobe", {7'b0, kbd_strobe}, 8'h01);
    check("enter_read", data_out, 8'h8D);
    bus_clear();
    tick();
    check("clr_strobe", {7'b0, kbd_strobe}, 8'h00);
    check("clr_keeps_data", data_out, 8'h0D);
    while (cyc < k + DEB + 1 + RDL - 1) tick();
    check("pre_rep_strobe", {7'b0, kbd_strobe}, 8'h00);
    bus_clear();
    tick();
    check("collide_strobe", {7'b0, kbd_strobe}, 8'h01);
    check("collide_read", data_out, 8'h8D);
    addr = 16'hC010;
    #1;
    check("rd_c010_zero", data_out, 8'h00);
    addr = 16'hC00F;
    #1;
    check("rd_c00f", data_out, 8'h8D);
    addr  = 16'hC000;
    rd_en = 1'b0;
    #1;
    check("no_rd_zero", data_out, 8'h00);
    keycode = 8'h00;
    bus_clear();
    run(10);

    // Unmapped key: no latch; rollover to a mapped key latches.
    press(8'h32, 1'b0, 40);
    press(8'h2C, 1'b0, 10);
    press(8'h00, 1'b0, 5);
    check("q_empty_b", 8'(exp_q.size()), 8'h00);

    // Asynchronous reset while repeating with the strobe set.
    k = cyc;
    keycode = 8'h1E;
    shift   = 1'b1;
    while (cyc < k + DEB + 1 + RDL + 1) tick();
    check("pre_rst_strobe", {7'b0, kbd_strobe}, 8'h01);
    check("pre_rst_read", data_out, 8'hA1);
    Reset = 1'b1;
    #1;
    check("async_strobe", {7'b0, kbd_strobe}, 8'h00);
    check("async_data", data_out, 8'h00);
    check("async_gen_kc", gen_keycode, 8'h00);
    tick();
    Reset = 1'b0;
    push_latches(8'h1E, 1'b1, 12);
    run(12);
    press(8'h00, 1'b0, 5);
    check("q_empty_c", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
